key_conditioner: RTL and testbench

//  Conditions raw board push-buttons before they reach game_top keys_i.
//  Per key: 2-flop synchroniser, polarity normalisation, counter debounce,

---
 rtl/key_conditioner.sv | 92 +++++++++
 tb/tb_key_conditioner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-key 2-flop sync, polarity fix, counter debounce,
// press/release pulses and a per-frame sticky press flag.
// Ports: clk_i, rst_i (async, active-low), keys_raw_i, new_frame_i ->
//        keys_o (debounced level), press_o, release_o, frame_press_o.
module key_conditioner #(
   parameter int N_KEYS         = 4,
   parameter int CLK_HZ         = 50_000_000,
   parameter int DEBOUNCE_MS    = 10,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N_KEYS-1:0] keys_raw_i,
   input  logic              new_frame_i,
   output logic [N_KEYS-1:0] keys_o,
   output logic [N_KEYS-1:0] press_o,
   output logic [N_KEYS-1:0] release_o,
   output logic [N_KEYS-1:0] frame_press_o
);

   localparam int CNT_MAX = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_TERM = CW'(CNT_MAX - 1);
   // Raw pin level of a released key.
   localparam logic [N_KEYS-1:0] IDLE_RAW = {N_KEYS{KEY_ACTIVE_LOW}};

   if (CNT_MAX < 2) begin : g_bad_cfg
      $error("key_conditioner: CNT_MAX must be at least 2");
   end

   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;
   logic [N_KEYS-1:0] r_keys;
   logic [N_KEYS-1:0] r_press;
   logic [N_KEYS-1:0] r_release;
   logic [N_KEYS-1:0] r_frame;
   logic [N_KEYS-1:0] w_ks;
   logic [N_KEYS-1:0] w_diff;
   logic [N_KEYS-1:0] w_term;

   // Normalised synced level: 1 = pressed.
   assign w_ks   = r_sync2 ^ IDLE_RAW;
   assign w_diff = w_ks ^ r_keys;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_sync1 <= IDLE_RAW;
         r_sync2 <= IDLE_RAW;
      end else begin
         r_sync1 <= keys_raw_i;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      logic [CW-1:0] r_cnt;

      // Terminal count: the new level has been stable for CNT_MAX cycles.
      assign w_term[g] = w_diff[g] && (r_cnt == CNT_TERM);

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            r_cnt <= '0;
         end else if (!w_diff[g] || w_term[g]) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_keys    <= '0;
         r_press   <= '0;
         r_release <= '0;
         r_frame   <= '0;
      end else begin
         r_keys    <= r_keys ^ w_term;
         r_press   <= w_term & w_ks;
         r_release <= w_term & ~w_ks;
         // A press coinciding with new_frame_i belongs to the coming frame.
         r_frame   <= r_press | (r_frame & ~{N_KEYS{new_frame_i}});
      end
   end

   assign keys_o        = r_keys;
   assign press_o       = r_press;
   assign release_o     = r_release;
   assign frame_press_o = r_frame;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed + randomized bench for key_conditioner
// against a window-based behavioural model (CNT_MAX=4, active-low keys).
module tb_key_conditioner;

   localparam int N       = 4;
   localparam int CNT_MAX = 4;
   localparam int LAT     = CNT_MAX + 2;

   logic         clk_i       = 1'b0;
   logic         rst_i       = 1'b0;
   logic [N-1:0] keys_raw_i  = '1;
   logic         new_frame_i = 1'b0;
   logic [N-1:0] keys_o;
   logic [N-1:0] press_o;
   logic [N-1:0] release_o;
   logic [N-1:0] frame_press_o;

   key_conditioner #(
      .N_KEYS        (N),
      .CLK_HZ        (1000),
      .DEBOUNCE_MS   (4),
      .KEY_ACTIVE_LOW(1'b1)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .keys_raw_i   (keys_raw_i),
      .new_frame_i  (new_frame_i),
      .keys_o       (keys_o),
      .press_o      (press_o),
      .release_o    (release_o),
      .frame_press_o(frame_press_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Model: a key's level flips once its normalised synced value has
   // disagreed with the current level for CNT_MAX consecutive edges.
   // Synced value at an edge = raw pin sampled two edges earlier.
   logic [N-1:0] h [LAT];
   logic [N-1:0] m_keys  = '0;
   logic [N-1:0] m_press = '0;
   logic [N-1:0] m_rel   = '0;
   logic [N-1:0] m_fp    = '0;

   always @(posedge clk_i) begin
      cyc++;
      if (!rst_i) begin
         for (int i = 0; i < LAT; i++) h[i] = '1;
         m_keys  = '0;
         m_press = '0;
         m_rel   = '0;
         m_fp    = '0;
      end else begin
         m_fp    = m_press | (m_fp & ~{N{new_frame_i}});
         m_press = '0;
         m_rel   = '0;
         for (int k = 0; k < N; k++) begin
            bit st;
            st = 1'b1;
            for (int j = 1; j <= CNT_MAX; j++)
               if (!h[j][k] == m_keys[k]) st = 1'b0;
            if (st) begin
               m_keys[k] = !m_keys[k];
               if (m_keys[k]) m_press[k] = 1'b1;
               else           m_rel[k]   = 1'b1;
            end
         end
         for (int i = LAT - 1; i > 0; i--) h[i] = h[i-1];
         h[0] = keys_raw_i;
      end
   end

   always @(negedge clk_i) begin
      if (cmp_en) begin
         if (!rst_i) begin
            chk("in_reset", {keys_o, press_o, release_o, frame_press_o}, '0);
         end else begin
            chk("keys",   keys_o,        m_keys);
            chk("press",  press_o,       m_press);
            chk("rel",    release_o,     m_rel);
            chk("fpress", frame_press_o, m_fp);
            chk("excl",   press_o & release_o, '0);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic lat_to(input int k, input logic lvl, output int lat);
      lat = 0;
      while (keys_o[k] !== lvl && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic frame();
      new_frame_i = 1'b1;
      step();
      new_frame_i = 1'b0;
   endtask

   int           lat;
   int           p;
   int           st_c [N];
   logic [N-1:0] seen;

   initial begin
      #1;
      chk("rst_outs", {keys_o, press_o, release_o, frame_press_o}, '0);
      cmp_en = 1'b1;
      idle(3);
      rst_i = 1'b1;
      idle(3);

      // Clean press on key0
      keys_raw_i[0] = 1'b0;
      lat_to(0, 1'b1, lat);
      chk("t1_lat", lat, 6);
      chk("t1_press", press_o[0], 1);
      step();
      chk("t1_press_1cyc", press_o[0], 0);
      chk("t1_fp_set", frame_press_o[0], 1);

      // Release key0; sticky flag survives until a frame
      idle(2);
      keys_raw_i[0] = 1'b1;
      lat_to(0, 1'b0, lat);
      chk("t3_lat", lat, 6);
      chk("t3_rel", release_o[0], 1);
      chk("t3_fp_held", frame_press_o[0], 1);
      step();
      chk("t3_rel_1cyc", release_o[0], 0);
      frame();
      chk("t3_fp_clr", frame_press_o[0], 0);

      // Bounce shorter than debounce, then a real press
      idle(2);
      keys_raw_i[0] = 1'b0;
      idle(3);
      keys_raw_i[0] = 1'b1;
      p = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (press_o[0]) p++;
      end
      chk("t2_no_press", p, 0);
      chk("t2_keys_low", keys_o[0], 0);
      keys_raw_i[0] = 1'b0;
      lat_to(0, 1'b1, lat);
      chk("t2_lat", lat, 6);
      keys_raw_i[0] = 1'b1;
      idle(10);
      frame();

      // Press on key1 coinciding with new_frame_i
      keys_raw_i[1] = 1'b0;
      idle(6);
      chk("t4_press", press_o[1], 1);
      frame();
      chk("t4_fp_kept", frame_press_o[1], 1);
      idle(2);
      frame();
      chk("t4_fp_clr", frame_press_o[1], 0);
      keys_raw_i[1] = 1'b1;
      idle(10);

      // Staggered presses on all keys
      seen = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < N) begin
            keys_raw_i[i] = 1'b0;
            st_c[i] = cyc;
         end
         step();
         for (int k = 0; k < N; k++)
            if (keys_o[k] && !seen[k]) begin
               seen[k] = 1'b1;
               chk($sformatf("t5_lat%0d", k), cyc - st_c[k], 6);
            end
      end
      chk("t5_all", seen, 4'hF);
      keys_raw_i = '1;
      idle(10);

      // Reset mid-count, then while pressed
      keys_raw_i[0] = 1'b0;
      idle(3);
      rst_i = 1'b0;
      #1;
      chk("t6_async_cnt", {keys_o, press_o, release_o, frame_press_o}, '0);
      step();
      rst_i = 1'b1;
      lat_to(0, 1'b1, lat);
      chk("t6_lat_a", lat, 6);
      chk("t6_press_a", press_o[0], 1);
      idle(2);
      rst_i = 1'b0;
      #1;
      chk("t6_async_held", {keys_o, press_o, release_o, frame_press_o}, '0);
      step();
      rst_i = 1'b1;
      p = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (press_o[0]) p++;
         if (i == 5) chk("t6_lat_b", keys_o[0], 1);
         if (i == 4) chk("t6_early", keys_o[0], 0);
      end
      chk("t6_one_press", p, 1);
      keys_raw_i = '1;
      idle(10);

      // Randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < N; k++)
            if ($urandom_range(0, 5) == 0) keys_raw_i[k] = ~keys_raw_i[k];
         new_frame_i = ($urandom_range(0, 9) == 0);
         rst_i = ($urandom_range(0, 399) != 0);
         step();
      end
      rst_i = 1'b1;
      new_frame_i = 1'b0;
      idle(2);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
